// File: rtl/seg7_scan.sv
// Two-digit multiplexed seven-segment scanner with per-frame input snapshot.
// Optional: define LEADING_ZERO_BLANK_EN to blank the high digit when it is zero.
module seg7_scan #(
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned GAP_CYC    = 16,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic       ck,
  input  logic       rst,
  input  logic [3:0] seg1,
  input  logic [3:0] seg0,
  output logic [1:0] an,
  output logic [6:0] cat,
  output logic       frame
);

  localparam int unsigned CNT_MAX = ((PRESCALE > GAP_CYC) ? PRESCALE : GAP_CYC) - 1;
  localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {SHOW0, GAP0, SHOW1, GAP1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last;
  logic [3:0]    hi, lo;
  logic [1:0]    an_on;
  logic [6:0]    cat_on;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    unique case (d)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  always_comb begin
    state_nxt = state;
    last      = (state == SHOW0 || state == SHOW1) ? (cnt == SHOW_LAST) : (cnt == GAP_LAST);
    if (last) begin
      unique case (state)
        SHOW0:   state_nxt = GAP0;
        GAP0:    state_nxt = SHOW1;
        SHOW1:   state_nxt = GAP1;
        default: state_nxt = SHOW0;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state <= GAP1;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      frame <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= last ? '0 : cnt + 1'b1;
      frame <= last && (state == GAP1);
      // Snapshot only on the edge entering SHOW0 so a mid-scan load never tears.
      if (last && (state == GAP1)) begin
        hi <= seg1;
        lo <= seg0;
      end
    end
  end

  always_comb begin
    an_on  = '0;
    cat_on = '0;
    unique case (state)
      SHOW0: begin
        an_on  = 2'b01;
        cat_on = glyph(lo);
      end
      SHOW1: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (hi != 4'h0) begin
          an_on  = 2'b10;
          cat_on = glyph(hi);
        end
`else
        an_on  = 2'b10;
        cat_on = glyph(hi);
`endif
      end
      default: ;
    endcase
  end

  assign an  = (ACTIVE_LOW != 0) ? ~an_on  : an_on;
  assign cat = (ACTIVE_LOW != 0) ? ~cat_on : cat_on;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan: active-low and active-high instances side by side.
module tb_seg7_scan;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] seg1 = 4'h9;
  logic [3:0] seg0 = 4'hF;
  logic [1:0] an_al, an_ah;
  logic [6:0] cat_al, cat_ah;
  logic       frame_al, frame_ah;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [1:0] LZ_AN  = 2'b11;
  localparam logic [6:0] LZ_CAT = 7'h7F;
`else
  localparam logic [1:0] LZ_AN  = 2'b01;
  localparam logic [6:0] LZ_CAT = 7'h40;
`endif

  seg7_scan #(.PRESCALE(4), .GAP_CYC(2), .ACTIVE_LOW(1)) dut (
    .ck(ck), .rst(rst), .seg1(seg1), .seg0(seg0),
    .an(an_al), .cat(cat_al), .frame(frame_al)
  );

  seg7_scan #(.PRESCALE(4), .GAP_CYC(2), .ACTIVE_LOW(0)) dut_ah (
    .ck(ck), .rst(rst), .seg1(seg1), .seg0(seg0),
    .an(an_ah), .cat(cat_ah), .frame(frame_ah)
  );

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_al"}, {an_al, cat_al}, {2'b11, 7'h7F});
    chk({tag, "_ah"}, {an_ah, cat_ah}, 9'h000);
    chk({tag, "_frame"}, {7'h00, frame_ah, frame_al}, 9'h000);
  endtask

  // Called one cycle before the snapshot edge; covers one full 12-cycle frame.
  // Inputs are switched to n1/n0 during SHOW1 to prove they stay hidden.
  task automatic run_frame(input string tag, input logic [6:0] c0, input logic [1:0] a1,
                           input logic [6:0] c1, input logic [3:0] n1, input logic [3:0] n0);
    logic [1:0] ea;
    logic [6:0] ec;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 4) begin
        ea = 2'b10; ec = c0;
      end else if (i >= 6 && i < 10) begin
        ea = a1; ec = c1;
      end else begin
        ea = 2'b11; ec = 7'h7F;
      end
      chk($sformatf("%s_al[%0d]", tag, i), {an_al, cat_al}, {ea, ec});
      chk($sformatf("%s_ah[%0d]", tag, i), {an_ah, cat_ah}, ~{ea, ec});
      chk($sformatf("%s_frame[%0d]", tag, i), {7'h00, frame_ah, frame_al},
          (i == 0) ? 9'h003 : 9'h000);
      if (i == 7) begin
        seg1 = n1;
        seg0 = n0;
      end
    end
  endtask

  initial begin
    tick();
    chk_reset("reset1");
    tick();
    chk_reset("reset2");
    rst = 1'b0;
    tick();
    chk_reset("post_rel1");

    run_frame("f9F", 7'h0E, 2'b01, 7'h10, 4'h0, 4'h7);
    run_frame("f07", 7'h78, LZ_AN, LZ_CAT, 4'h9, 4'hF);
    run_frame("f9F_b", 7'h0E, 2'b01, 7'h10, 4'h9, 4'hF);

    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_show1", {an_al, cat_al}, {2'b01, 7'h10});
    rst = 1'b1;
    tick();
    chk_reset("mid_rst");
    chk("mid_rst_shadow", {1'b0, dut.hi, dut.lo}, 9'h000);
    rst = 1'b0;
    tick();
    chk_reset("post_rel2");
    run_frame("restart", 7'h0E, 2'b01, 7'h10, 4'h9, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
